// File: rtl/vrot_32.sv
// Four-lane SIMD rotate-left unit: each 32-bit lane of state_in is rotated by the
// low log2(LANE_W) bits of the matching lane of bits_to_rotate; result registered once.
module vrot_32 #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [LANES*LANE_W-1:0]   state_in,
    input  logic [LANES*LANE_W-1:0]   bits_to_rotate,
    output logic [LANES*LANE_W-1:0]   state_out,
    output logic                      out_valid
);

    localparam int SHW = $clog2(LANE_W);

    logic [LANES*LANE_W-1:0] res;
    // Amount bits above SHW are deliberately discarded (rotation is mod LANE_W).
    logic [LANES-1:0]        unused_hi;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SHW-1:0]    amt;
        logic [LANE_W-1:0] stage [SHW+1];

        assign amt       = bits_to_rotate[l*LANE_W +: SHW];
        assign unused_hi[l] = ^bits_to_rotate[l*LANE_W+SHW +: LANE_W-SHW];
        assign stage[0]  = state_in[l*LANE_W +: LANE_W];

        // Stage s rotates by 2**s when amount bit s is set; amount 0 passes through.
        for (genvar s = 0; s < SHW; s++) begin : g_stage
            localparam int K = 1 << s;
            assign stage[s+1] = amt[s]
                ? {stage[s][LANE_W-1-K:0], stage[s][LANE_W-1 -: K]}
                : stage[s];
        end

        assign res[l*LANE_W +: LANE_W] = stage[SHW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (in_valid == 1'b1);
            if (in_valid == 1'b1) begin
                state_out <= res;
            end
        end
    end

endmodule

// File: tb/tb_vrot_32.sv
// Self-checking bench for vrot_32: directed vector table, reset/idle sequences,
// and randomized traffic against a bit-index rotate model.
module tb_vrot_32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] state_in;
    logic [127:0] bits_to_rotate;
    logic [127:0] state_out;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] s;
        logic [127:0] r;
        logic [127:0] e;
    } vec_t;

    vec_t vecs [3];

    vrot_32 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .state_in       (state_in),
        .bits_to_rotate (bits_to_rotate),
        .state_out      (state_out),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    // Result bit (j + amt) mod 32 of each lane receives source bit j.
    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] r);
        logic [127:0] res;
        res = '0;
        for (int l = 0; l < 4; l++) begin
            int unsigned amt;
            amt = r[l*32 +: 32] % 32;
            for (int j = 0; j < 32; j++) begin
                res[l*32 + int'((j + amt) % 32)] = s[l*32 + j];
            end
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        logic [127:0] m_state;
        logic         m_valid;
        logic         v;

        vecs[0] = '{s: 128'haabbccdd_eeff0011_2233bb00_aabbccdd,
                    r: 128'h00000008_00000010_00000018_00000020,
                    e: 128'hbbccddaa_0011eeff_002233bb_aabbccdd};
        vecs[1] = '{s: 128'h44000011_33000022_55000077_11000044,
                    r: 128'h00000028_00000030_00000038_00000040,
                    e: 128'h00001144_00223300_77550000_11000044};
        vecs[2] = '{s: 128'h80000001_80000001_80000001_80000001,
                    r: 128'h00000001_0000001f_00000000_ffffffe1,
                    e: 128'h00000003_c0000000_80000001_00000003};

        rst_n          = 1'b0;
        in_valid       = 1'b0;
        state_in       = '0;
        bits_to_rotate = '0;
        step();
        step();
        check128("reset_state_out", state_out, 128'h0);
        check1("reset_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        step();
        check1("post_reset_idle_valid", out_valid, 1'b0);

        // Directed vectors back-to-back: each result appears exactly one cycle later.
        for (int i = 0; i < 3; i++) begin
            in_valid       = 1'b1;
            state_in       = vecs[i].s;
            bits_to_rotate = vecs[i].r;
            step();
            check128($sformatf("vec%0d_state_out", i), state_out, vecs[i].e);
            check1($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
        end

        // Idle with junk inputs: valid drops, data holds last result.
        in_valid       = 1'b0;
        state_in       = 'x;
        bits_to_rotate = 'x;
        for (int k = 0; k < 2; k++) begin
            step();
            check1("idle_out_valid", out_valid, 1'b0);
            check128("idle_hold", state_out, vecs[2].e);
        end

        // Asynchronous reset in the middle of a valid stream.
        in_valid       = 1'b1;
        state_in       = vecs[0].s;
        bits_to_rotate = vecs[0].r;
        step();
        check1("pre_async_valid", out_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check128("async_reset_state_out", state_out, 128'h0);
        check1("async_reset_out_valid", out_valid, 1'b0);
        step();
        check128("reset_held_state_out", state_out, 128'h0);
        check1("reset_held_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check1("release_idle_valid", out_valid, 1'b0);
        check128("release_idle_state", state_out, 128'h0);

        // First capture after release.
        in_valid       = 1'b1;
        state_in       = vecs[1].s;
        bits_to_rotate = vecs[1].r;
        step();
        check128("first_after_release", state_out, vecs[1].e);
        check1("first_after_release_valid", out_valid, 1'b1);

        m_state = vecs[1].e;
        m_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] s;
            logic [127:0] r;
            v = ($urandom_range(0, 3) != 0);
            s = {$urandom, $urandom, $urandom, $urandom};
            r = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                for (int l = 0; l < 4; l++) r[l*32 +: 32] = 32'($urandom_range(0, 40));
            end
            in_valid       = v;
            state_in       = s;
            bits_to_rotate = r;
            step();
            if (v) m_state = model(s, r);
            m_valid = v;
            check1("rand_out_valid", out_valid, m_valid);
            check128("rand_state_out", state_out, m_state);
        end

        in_valid = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
